// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter.
//   Bus writes to TXDATA queue bytes in a TX FIFO; a framing FSM pops them
//   and serialises start / 8 data bits (LSB first) / [parity] / stop on tx.
//   Register map (offset = Adr[3:2]):
//     0 TXDATA   W: push Data_out[7:0]; reads 0
//     1 STATUS   R: [0]busy [1]full [2]empty [3]overflow [7:4]count(sat 15)
//                   [8]parity supported; W: 1 to bit3 clears overflow
//     2 BAUD_DIV R/W [15:0] clk cycles per bit; 0 is stored as 1
//     3 -        reads 0, writes ignored
// Optional feature: define UART_PARITY_EN to add an even-parity bit.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   Adr, MemWrite  core byte address and write strobe
//   Data_out       core write data
//   sel            block decode (Adr[31:4] matches BASE_ADDR[31:4])
//   rd_data        combinational read data, 0 when not selected / unmapped
//   tx             serial line, idle high
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Adr,
    input  logic        MemWrite,
    input  logic [31:0] Data_out,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state, state_n;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wptr, rptr;
    logic [CW-1:0]  cnt;
    logic           overflow;
    logic [15:0]    baud_div;
    logic [15:0]    div_lat;
    logic [15:0]    timer;
    logic [7:0]     shift;
    logic [2:0]     bit_idx;
    logic           par;

    logic           wr_en, push, push_ok, pop, full, empty, busy, timer_zero;
    logic [1:0]     offset;
    logic [3:0]     cnt_sat;
    logic [31:0]    cnt_ext;
    logic           unused_ok;

    assign unused_ok = ^{Data_out[31:16], Adr[1:0]};

    // ---------------- bus decode ----------------
    assign sel     = (Adr[31:4] == BASE_ADDR[31:4]);
    assign offset  = Adr[3:2];
    assign wr_en   = sel & MemWrite;
    assign push    = wr_en && (offset == 2'd0);

    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign busy    = (state != IDLE);
    // A push into a full FIFO is still honoured when a pop frees a slot
    // on the same edge.
    assign push_ok = push && (!full || pop);

    assign cnt_ext = 32'(cnt);
    assign cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];

    always_comb begin
        rd_data = 32'd0;
        if (sel) begin
            case (offset)
                2'd1:    rd_data = {23'd0, PAR_EN, cnt_sat, overflow, empty, full, busy};
                2'd2:    rd_data = {16'd0, baud_div};
                default: rd_data = 32'd0;
            endcase
        end
    end

    // ---------------- registers and FIFO ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            baud_div <= DEFAULT_DIV;
        end else begin
            if (push_ok) begin
                mem[wptr] <= Data_out[7:0];
                wptr      <= wptr + PW'(1);
            end
            if (pop)
                rptr <= rptr + PW'(1);
            cnt <= cnt + CW'(push_ok) - CW'(pop);

            if (wr_en && (offset == 2'd1) && Data_out[3])
                overflow <= 1'b0;
            if (push && !push_ok)
                overflow <= 1'b1;

            if (wr_en && (offset == 2'd2))
                baud_div <= (Data_out[15:0] == 16'd0) ? 16'd1 : Data_out[15:0];
        end
    end

    // ---------------- framing FSM ----------------
    assign timer_zero = (timer == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_lat <= DEFAULT_DIV;
            timer   <= '0;
            shift   <= '0;
            bit_idx <= '0;
            par     <= 1'b0;
        end else begin
            state <= state_n;
            if (pop) begin
                // Divider is captured per frame so mid-frame writes wait.
                shift   <= mem[rptr];
                par     <= ^mem[rptr];
                div_lat <= baud_div;
                timer   <= baud_div - 16'd1;
                bit_idx <= '0;
            end else if (state != IDLE) begin
                if (timer_zero) begin
                    timer <= div_lat - 16'd1;
                    if (state == DATA) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    timer <= timer - 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (timer_zero) state_n = DATA;
            end
            DATA: begin
                tx = shift[0];
                if (timer_zero && (bit_idx == 3'd7)) begin
`ifdef UART_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                tx = par;
                if (timer_zero) state_n = STOP;
            end
`endif
            STOP: begin
                if (timer_zero) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
